ucode_mem_arbiter: RTL and testbench

- Shares the single uCode program memory (one write port, one read port, one shared address, 1-cycle registered read) between three requesters.
- Requesters: host loader/debug port (h), CPU data access for @ and ! (d), CPU instruction fetch (f).
- Round-robin arbitration, one memory operation per cycle.
- Host exclusive-lock mode lets a loader write programs while the CPU is held off.

---
 rtl/ucode_mem_pkg.sv | 27 ++
 rtl/rr_arbiter3.sv | 75 +++++++
 rtl/ucode_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_ucode_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_mem_pkg.sv
// Shared definitions for the uCode program-memory arbiter: requester indices,
// arbiter states and the memory geometry defaults used by the CPU.
package ucode_mem_pkg;

  localparam int DATA_SZ_DEF = 16;
  localparam int ADDR_SZ_DEF = 8;

  localparam logic [1:0] REQ_H = 2'd0;
  localparam logic [1:0] REQ_D = 2'd1;
  localparam logic [1:0] REQ_F = 2'd2;

  typedef enum logic [1:0] {
    ST_RR     = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Requester that follows idx in the circular h -> d -> f order.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    case (idx)
      REQ_H:   return REQ_D;
      REQ_D:   return REQ_F;
      default: return REQ_H;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: combinational one-hot grant starting at the
// pointer, pointer advanced past the winner (or force-loaded) at the clock edge.
module rr_arbiter3
  import ucode_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  input  logic       ptr_load_i,
  input  logic [1:0] ptr_load_val_i,
  output logic [2:0] gnt_o
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [2:0] rot;
  logic [2:0] rot_gnt;
  logic [1:0] win_idx;

  // Rotate requests so bit 0 is the pointer, pick the first, rotate back.
  always_comb begin
    rot   = req_i;
    gnt_o = 3'b000;
    case (ptr_q)
      REQ_H:   rot = req_i;
      REQ_D:   rot = {req_i[0], req_i[2], req_i[1]};
      REQ_F:   rot = {req_i[1], req_i[0], req_i[2]};
      default: rot = req_i;
    endcase
    if (rot[0]) begin
      rot_gnt = 3'b001;
    end else if (rot[1]) begin
      rot_gnt = 3'b010;
    end else if (rot[2]) begin
      rot_gnt = 3'b100;
    end else begin
      rot_gnt = 3'b000;
    end
    case (ptr_q)
      REQ_H:   gnt_o = rot_gnt;
      REQ_D:   gnt_o = {rot_gnt[1], rot_gnt[0], rot_gnt[2]};
      REQ_F:   gnt_o = {rot_gnt[0], rot_gnt[2], rot_gnt[1]};
      default: gnt_o = rot_gnt;
    endcase
  end

  // Next pointer: forced load wins, otherwise move past the winner.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[2]) begin
      win_idx = REQ_F;
    end else if (gnt_o[1]) begin
      win_idx = REQ_D;
    end else begin
      win_idx = REQ_H;
    end
    if (ptr_load_i) begin
      ptr_d = ptr_load_val_i;
    end else if (gnt_o != 3'b000) begin
      ptr_d = rr_next(win_idx);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= REQ_H;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ucode_mem_arbiter.sv
// Shares the single-ported uCode memory between host loader, CPU data and CPU
// fetch; one op per cycle, round-robin, with a host exclusive-lock mode.
module ucode_mem_arbiter
  import ucode_mem_pkg::*;
#(
  parameter int DATA_SZ = DATA_SZ_DEF,
  parameter int ADDR_SZ = ADDR_SZ_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_h_req,
  input  logic               i_h_wr,
  input  logic [ADDR_SZ-1:0] i_h_addr,
  input  logic [DATA_SZ-1:0] i_h_wdata,
  input  logic               i_h_lock,
  output logic               o_h_locked,
  output logic               o_h_ack,
  output logic               o_h_rvalid,
  input  logic               i_d_req,
  input  logic               i_d_wr,
  input  logic [ADDR_SZ-1:0] i_d_addr,
  input  logic [DATA_SZ-1:0] i_d_wdata,
  output logic               o_d_ack,
  output logic               o_d_rvalid,
  input  logic               i_f_req,
  input  logic [ADDR_SZ-1:0] i_f_addr,
  output logic               o_f_ack,
  output logic               o_f_rvalid,
  output logic [DATA_SZ-1:0] o_rdata,
  output logic               o_mem_wr,
  output logic [ADDR_SZ-1:0] o_mem_addr,
  output logic [DATA_SZ-1:0] o_mem_wdata,
  input  logic [DATA_SZ-1:0] i_mem_rdata
);

  arb_state_e         state_q, state_d;
  logic [2:0]         ack_q, rvalid_q;
  logic               locked_q;
  logic               mem_wr_q, mem_wr_d;
  logic [ADDR_SZ-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_SZ-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]         allow;
  logic [2:0]         req_eff;
  logic [2:0]         gnt;
  logic               ptr_load;

  // Lock sequencing and which requesters may compete this cycle.
  always_comb begin
    state_d  = state_q;
    allow    = 3'b000;
    ptr_load = 1'b0;
    case (state_q)
      ST_RR: begin
        if (i_h_lock) begin
          allow   = 3'b001;
          state_d = ST_DRAIN;
        end else begin
          allow   = 3'b111;
          state_d = ST_RR;
        end
      end
      ST_DRAIN: begin
        allow = 3'b000;
        if (i_h_lock) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_RR;
        end
      end
      ST_LOCKED: begin
        allow = 3'b001;
        if (i_h_lock) begin
          state_d = ST_LOCKED;
        end else begin
          state_d  = ST_RR;
          ptr_load = 1'b1;
        end
      end
      default: begin
        allow   = 3'b000;
        state_d = ST_RR;
      end
    endcase
  end

  // A requester acked this cycle is still holding its old request; mask it.
  assign req_eff = {i_f_req, i_d_req, i_h_req} & ~ack_q & allow;

  rr_arbiter3 u_rr (
    .clk_i          (i_clk),
    .rst_i          (i_rst),
    .req_i          (req_eff),
    .ptr_load_i     (ptr_load),
    .ptr_load_val_i (REQ_D),
    .gnt_o          (gnt)
  );

  // Memory command of the winner; address and data hold when idle.
  always_comb begin
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (gnt[REQ_H]) begin
      mem_wr_d   = i_h_wr;
      mem_addr_d = i_h_addr;
      if (i_h_wr) begin
        mem_wdata_d = i_h_wdata;
      end else begin
        mem_wdata_d = mem_wdata_q;
      end
    end else if (gnt[REQ_D]) begin
      mem_wr_d   = i_d_wr;
      mem_addr_d = i_d_addr;
      if (i_d_wr) begin
        mem_wdata_d = i_d_wdata;
      end else begin
        mem_wdata_d = mem_wdata_q;
      end
    end else if (gnt[REQ_F]) begin
      mem_addr_d = i_f_addr;
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  // State, handshake and memory-command registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_RR;
      ack_q       <= 3'b000;
      rvalid_q    <= 3'b000;
      locked_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= {ADDR_SZ{1'b0}};
      mem_wdata_q <= {DATA_SZ{1'b0}};
    end else begin
      state_q     <= state_d;
      ack_q       <= gnt;
      rvalid_q    <= ack_q & {3{~mem_wr_q}};
      locked_q    <= (state_d == ST_LOCKED);
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_h_ack     = ack_q[REQ_H];
  assign o_d_ack     = ack_q[REQ_D];
  assign o_f_ack     = ack_q[REQ_F];
  assign o_h_rvalid  = rvalid_q[REQ_H];
  assign o_d_rvalid  = rvalid_q[REQ_D];
  assign o_f_rvalid  = rvalid_q[REQ_F];
  assign o_h_locked  = locked_q;
  assign o_mem_wr    = mem_wr_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_rdata     = i_mem_rdata;

endmodule

// File: tb/tb_ucode_mem_arbiter.sv
// Self-checking bench for ucode_mem_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural arbiter/memory model.
module tb_ucode_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        h_req, h_wr, h_lock, d_req, d_wr, f_req;
  logic [7:0]  h_addr, d_addr, f_addr;
  logic [15:0] h_wdata, d_wdata;
  logic        h_locked, h_ack, h_rvalid, d_ack, d_rvalid, f_ack, f_rvalid;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic        mem_wr;
  logic [7:0]  mem_addr;

  ucode_mem_arbiter #(.DATA_SZ(16), .ADDR_SZ(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_h_req(h_req), .i_h_wr(h_wr), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
    .i_h_lock(h_lock), .o_h_locked(h_locked), .o_h_ack(h_ack), .o_h_rvalid(h_rvalid),
    .i_d_req(d_req), .i_d_wr(d_wr), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack), .o_d_rvalid(d_rvalid),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_ack(f_ack), .o_f_rvalid(f_rvalid),
    .o_rdata(rdata), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Memory: registered read, writes posted one edge before reaching the array.
  logic [15:0] mem [256];
  logic        post_v, mem_init, pre_en;
  logic [7:0]  post_a, pre_a;
  logic [15:0] post_d, pre_d;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 37 + 5);
      post_v <= 1'b0;
    end else begin
      if (post_v) mem[post_a] <= post_d;
      if (pre_en) mem[pre_a] <= pre_d;
      post_v <= mem_wr;
    end
    post_a    <= mem_addr;
    post_d    <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h_req = 1'b0; h_wr = 1'b0; h_addr = 8'h00; h_wdata = 16'h0000; h_lock = 1'b0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = 8'h00; d_wdata = 16'h0000;
    f_req = 1'b0; f_addr = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0] req;   // {f,d,h}
    logic       h_wr;
    logic [7:0] h_addr;
    logic       lock;
    logic [2:0] ack;   // expected in the following cycle
    logic [2:0] rv;
    logic       mw;
    logic       locked;
  } vec_t;

  function automatic vec_t mk(logic [2:0] rq, logic hw, logic [7:0] ha, logic lk,
                              logic [2:0] ak, logic [2:0] rv, logic mw, logic lkd);
    vec_t v;
    v.req = rq; v.h_wr = hw; v.h_addr = ha; v.lock = lk;
    v.ack = ak; v.rv = rv; v.mw = mw; v.locked = lkd;
    return v;
  endfunction

  vec_t tbl[18];

  // Reference model state
  typedef struct { int who; int due; logic [15:0] data; } rd_t;
  typedef struct { logic [7:0] a; logic [15:0] d; int g; } wr_t;
  rd_t         rdq[$];
  wr_t         wrq[$];
  logic [15:0] shadow [256];
  int          m_ptr, m_mode, m_last;   // mode: 0 round-robin, 1 drain, 2 locked
  logic        a_req[3], a_wr[3];
  logic [7:0]  a_addr[3];
  logic [15:0] a_wd[3];
  logic [2:0]  e_ack, e_rv;
  logic        e_mw, e_lk;
  logic [7:0]  e_addr;
  logic [15:0] e_wdata, e_rdata;

  task automatic model_step(input int t, input logic lock);
    int  win;
    int  nmode;
    bit  ok;
    while (wrq.size() > 0 && wrq[0].g <= t - 2) begin
      shadow[wrq[0].a] = wrq[0].d;
      void'(wrq.pop_front());
    end
    win = -1;
    for (int j = 0; j < 3; j++) begin
      int k;
      k  = (m_ptr + j) % 3;
      ok = (m_mode == 0) ? (!lock || k == 0) : (m_mode == 2 && k == 0);
      if (win < 0 && a_req[k] && k != m_last && ok) win = k;
    end
    if (m_mode == 0)      nmode = lock ? 1 : 0;
    else if (m_mode == 1) nmode = lock ? 2 : 0;
    else                  nmode = lock ? 2 : 0;
    e_ack = 3'b000;
    e_mw  = 1'b0;
    if (win >= 0) begin
      e_ack  = 3'(1 << win);
      e_mw   = a_wr[win];
      e_addr = a_addr[win];
      if (a_wr[win]) begin
        e_wdata = a_wd[win];
        wrq.push_back('{a: a_addr[win], d: a_wd[win], g: t});
      end else begin
        rdq.push_back('{who: win, due: t + 2, data: shadow[a_addr[win]]});
      end
      m_ptr = (win + 1) % 3;
    end
    if (m_mode == 2 && !lock) m_ptr = 1;
    m_last = win;
    m_mode = nmode;
    e_lk   = (nmode == 2);
    e_rv   = 3'b000;
    if (rdq.size() > 0 && rdq[0].due == t + 1) begin
      e_rv    = 3'(1 << rdq[0].who);
      e_rdata = rdq[0].data;
      void'(rdq.pop_front());
    end
  endtask

  initial begin
    logic lock_r;
    int   lock_cnt;
    idle();
    pre_en = 1'b0; pre_a = 8'h00; pre_d = 16'h0000;
    mem_init = 1'b1;
    rst = 1'b1;
    tick();
    mem_init = 1'b0;
    tick();
    rst = 1'b0;

    // Round robin, lock/drain/locked/release and lock dropped in drain.
    tbl[0]  = mk(3'b111, 1'b0, 8'h00, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    tbl[1]  = mk(3'b111, 1'b0, 8'h00, 1'b0, 3'b010, 3'b001, 1'b0, 1'b0);
    tbl[2]  = mk(3'b111, 1'b0, 8'h00, 1'b0, 3'b100, 3'b010, 1'b0, 1'b0);
    tbl[3]  = mk(3'b111, 1'b0, 8'h00, 1'b0, 3'b001, 3'b100, 1'b0, 1'b0);
    tbl[4]  = mk(3'b111, 1'b0, 8'h00, 1'b0, 3'b010, 3'b001, 1'b0, 1'b0);
    tbl[5]  = mk(3'b111, 1'b0, 8'h00, 1'b1, 3'b001, 3'b010, 1'b0, 1'b0);
    tbl[6]  = mk(3'b111, 1'b0, 8'h00, 1'b1, 3'b000, 3'b001, 1'b0, 1'b1);
    tbl[7]  = mk(3'b111, 1'b1, 8'h80, 1'b1, 3'b001, 3'b000, 1'b1, 1'b1);
    tbl[8]  = mk(3'b111, 1'b1, 8'h81, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1);
    tbl[9]  = mk(3'b111, 1'b1, 8'h81, 1'b1, 3'b001, 3'b000, 1'b1, 1'b1);
    tbl[10] = mk(3'b110, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    tbl[11] = mk(3'b110, 1'b0, 8'h00, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0);
    tbl[12] = mk(3'b110, 1'b0, 8'h00, 1'b0, 3'b100, 3'b010, 1'b0, 1'b0);
    tbl[13] = mk(3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0);
    tbl[14] = mk(3'b000, 1'b0, 8'h00, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    tbl[15] = mk(3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    tbl[16] = mk(3'b011, 1'b0, 8'h00, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    tbl[17] = mk(3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0);

    chk("reset_ack", {29'd0, f_ack, d_ack, h_ack}, 32'd0);
    chk("reset_locked", {31'd0, h_locked}, 32'd0);
    d_addr = 8'h11; f_addr = 8'h22;
    for (int i = 0; i < 18; i++) begin
      {f_req, d_req, h_req} = tbl[i].req;
      h_wr = tbl[i].h_wr; h_addr = tbl[i].h_addr; h_lock = tbl[i].lock;
      h_wdata = {8'h5A, tbl[i].h_addr};
      tick();
      chk($sformatf("tbl%0d_ack", i), {29'd0, f_ack, d_ack, h_ack}, {29'd0, tbl[i].ack});
      chk($sformatf("tbl%0d_rvalid", i), {29'd0, f_rvalid, d_rvalid, h_rvalid}, {29'd0, tbl[i].rv});
      chk($sformatf("tbl%0d_memwr", i), {31'd0, mem_wr}, {31'd0, tbl[i].mw});
      chk($sformatf("tbl%0d_locked", i), {31'd0, h_locked}, {31'd0, tbl[i].locked});
      if (tbl[i].mw) begin
        chk($sformatf("tbl%0d_memaddr", i), {24'd0, mem_addr}, {24'd0, tbl[i].h_addr});
        chk($sformatf("tbl%0d_memwdata", i), {16'd0, mem_wdata}, {16'd0, 8'h5A, tbl[i].h_addr});
      end
    end

    // Single fetch of a known word.
    idle();
    pre_en = 1'b1; pre_a = 8'h02; pre_d = 16'h0080;
    do_reset();
    pre_en = 1'b0;
    f_req = 1'b1; f_addr = 8'h02;
    tick();
    chk("fetch_ack", {29'd0, f_ack, d_ack, h_ack}, 32'h4);
    chk("fetch_addr", {24'd0, mem_addr}, 32'h02);
    f_req = 1'b0;
    tick();
    chk("fetch_rvalid", {29'd0, f_rvalid, d_rvalid, h_rvalid}, 32'h4);
    chk("fetch_rdata", {16'd0, rdata}, 32'h0080);
    chk("fetch_noack", {29'd0, f_ack, d_ack, h_ack}, 32'h0);

    // Read-after-write ordering.
    pre_en = 1'b1; pre_a = 8'h90; pre_d = 16'hBEEF;
    do_reset();
    pre_en = 1'b0;
    h_req = 1'b1; h_wr = 1'b1; h_addr = 8'h90; h_wdata = 16'h1234;
    tick();
    chk("raw_h_ack", {29'd0, f_ack, d_ack, h_ack}, 32'h1);
    chk("raw_memwr", {31'd0, mem_wr}, 32'h1);
    h_req = 1'b0; h_wr = 1'b0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 8'h90;
    f_req = 1'b1; f_addr = 8'h90;
    tick();
    chk("raw_d_ack", {29'd0, f_ack, d_ack, h_ack}, 32'h2);
    d_req = 1'b0;
    tick();
    chk("raw_f_ack", {29'd0, f_ack, d_ack, h_ack}, 32'h4);
    chk("raw_d_rvalid", {29'd0, f_rvalid, d_rvalid, h_rvalid}, 32'h2);
    chk("raw_old_data", {16'd0, rdata}, 32'hBEEF);
    f_req = 1'b0;
    tick();
    chk("raw_f_rvalid", {29'd0, f_rvalid, d_rvalid, h_rvalid}, 32'h4);
    chk("raw_new_data", {16'd0, rdata}, 32'h1234);

    // Reset on the ack cycle of a data read.
    idle();
    tick();
    d_req = 1'b1; d_addr = 8'h05;
    tick();
    chk("rstmid_d_ack", {29'd0, f_ack, d_ack, h_ack}, 32'h2);
    d_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_ack", {29'd0, f_ack, d_ack, h_ack}, 32'h0);
    chk("rstmid_rvalid", {29'd0, f_rvalid, d_rvalid, h_rvalid}, 32'h0);
    chk("rstmid_mem", {mem_wr, 7'd0, mem_addr}, 32'h0);
    chk("rstmid_wdata", {16'd0, mem_wdata}, 32'h0);
    chk("rstmid_locked", {31'd0, h_locked}, 32'h0);
    h_req = 1'b1; d_req = 1'b1; f_req = 1'b1;
    tick();
    chk("rstmid_tie", {29'd0, f_ack, d_ack, h_ack}, 32'h1);
    chk("rstmid_no_rvalid", {29'd0, f_rvalid, d_rvalid, h_rvalid}, 32'h0);

    // Randomized run against the reference model.
    idle();
    do_reset();
    tick(); tick(); tick();
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    m_ptr = 0; m_mode = 0; m_last = -1;
    e_ack = 3'b000; e_rv = 3'b000; e_mw = 1'b0; e_lk = 1'b0;
    e_addr = 8'h00; e_wdata = 16'h0000; e_rdata = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      a_req[k] = 1'b0; a_wr[k] = 1'b0; a_addr[k] = 8'h00; a_wd[k] = 16'h0000;
    end
    lock_r = 1'b0; lock_cnt = 20;
    for (int t = 0; t < 4000; t++) begin
      if (t > 0) tick();
      chk($sformatf("rnd%0d_ack", t), {29'd0, f_ack, d_ack, h_ack}, {29'd0, e_ack});
      chk($sformatf("rnd%0d_rvalid", t), {29'd0, f_rvalid, d_rvalid, h_rvalid}, {29'd0, e_rv});
      chk($sformatf("rnd%0d_memwr", t), {31'd0, mem_wr}, {31'd0, e_mw});
      chk($sformatf("rnd%0d_locked", t), {31'd0, h_locked}, {31'd0, e_lk});
      if (e_ack != 3'b000) chk($sformatf("rnd%0d_addr", t), {24'd0, mem_addr}, {24'd0, e_addr});
      if (e_mw) chk($sformatf("rnd%0d_wdata", t), {16'd0, mem_wdata}, {16'd0, e_wdata});
      if (e_rv != 3'b000) chk($sformatf("rnd%0d_rdata", t), {16'd0, rdata}, {16'd0, e_rdata});
      for (int k = 0; k < 3; k++) begin
        if (a_req[k] && e_ack[k]) a_req[k] = 1'b0;
        if (!a_req[k] && $urandom_range(0, 99) < 55) begin
          a_req[k]  = 1'b1;
          a_wr[k]   = (k == 2) ? 1'b0 : 1'($urandom_range(0, 1));
          a_addr[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
          a_wd[k]   = 16'($urandom);
        end
      end
      lock_cnt--;
      if (lock_cnt <= 0) begin
        lock_r   = ($urandom_range(0, 2) == 0);
        lock_cnt = $urandom_range(1, 12);
      end
      h_req = a_req[0]; h_wr = a_wr[0]; h_addr = a_addr[0]; h_wdata = a_wd[0];
      d_req = a_req[1]; d_wr = a_wr[1]; d_addr = a_addr[1]; d_wdata = a_wd[1];
      f_req = a_req[2]; f_addr = a_addr[2];
      h_lock = lock_r;
      model_step(t, lock_r);
    end

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
